// File: rtl/regfile_sequencer.sv
// Weight-write sequencer for a dual-port register file: pairs writes,
// flushes lone writes on timeout, and sequences clear/step requests.
module regfile_sequencer #(
    parameter int unsigned HOLD_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       clr_req,
    output logic       clr_ack,
    input  logic       step_valid,
    input  logic [7:0] step_count,
    output logic       step_ready,
    output logic       updateWeight,
    output logic       rfClear,
    output logic       updateTotalSteps,
    output logic [2:0] Addr1,
    output logic [2:0] Addr2,
    output logic [7:0] Data1,
    output logic [7:0] Data2,
    output logic [7:0] updatedSteps,
    output logic       busy,
    output logic       err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        ISSUE,
        CLEAR,
        STEP
    } state_e;

    localparam logic [8:0] EXPIRE = 9'(HOLD_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [8:0] tmr_inc;
    logic [2:0] a_addr_q, a_addr_d;
    logic [7:0] a_data_q, a_data_d;
    logic [2:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [7:0] data1_q, data1_d, data2_q, data2_d;
    logic [7:0] steps_q, steps_d;
    logic       err_q, err_d;
    logic       uw_q, uw_d, rfc_q, rfc_d, uts_q, uts_d;
    logic       busy_q, busy_d;
    logic       wr_acc, wr_ok;

    // Handshake is the one output that must react to same-cycle requests.
    assign wr_ready = ~reset & ~clr_req &
                      (((state_q == IDLE) & ~step_valid) | (state_q == HOLD));
    assign wr_acc   = wr_valid & wr_ready;
    assign wr_ok    = wr_acc & (wr_addr < 3'd6);
    assign tmr_inc  = {1'b0, tmr_q} + 9'd1;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        addr1_d  = addr1_q;
        data1_d  = data1_q;
        addr2_d  = addr2_q;
        data2_d  = data2_q;
        steps_d  = steps_q;
        err_d    = err_q | (wr_acc & ~(wr_addr < 3'd6));
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (step_valid) begin
                    state_d = STEP;
                    steps_d = step_count;
                end else if (wr_ok) begin
                    a_addr_d = wr_addr;
                    a_data_d = wr_data;
                    if (wr_last) begin
                        state_d = ISSUE;
                        addr1_d = wr_addr;
                        data1_d = wr_data;
                        addr2_d = wr_addr;
                        data2_d = wr_data;
                    end else begin
                        state_d = HOLD;
                        tmr_d   = 8'd0;
                    end
                end
            end
            HOLD: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (wr_ok) begin
                    state_d = ISSUE;
                    addr1_d = a_addr_q;
                    data1_d = a_data_q;
                    addr2_d = wr_addr;
                    data2_d = wr_data;
                end else if (!wr_acc) begin
                    // A dropped write leaves the timer untouched.
                    if (tmr_inc >= EXPIRE) begin
                        state_d = ISSUE;
                        addr1_d = a_addr_q;
                        data1_d = a_data_q;
                        addr2_d = a_addr_q;
                        data2_d = a_data_q;
                    end else begin
                        tmr_d = tmr_inc[7:0];
                    end
                end
            end
            ISSUE, CLEAR, STEP: state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    always_comb begin
        uw_d   = (state_d == ISSUE) | (state_d == CLEAR);
        rfc_d  = (state_d == CLEAR);
        uts_d  = (state_d == STEP);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tmr_q    <= 8'd0;
            a_addr_q <= 3'd0;
            a_data_q <= 8'd0;
            addr1_q  <= 3'd0;
            data1_q  <= 8'd0;
            addr2_q  <= 3'd0;
            data2_q  <= 8'd0;
            steps_q  <= 8'd0;
            err_q    <= 1'b0;
            uw_q     <= 1'b0;
            rfc_q    <= 1'b0;
            uts_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            addr1_q  <= addr1_d;
            data1_q  <= data1_d;
            addr2_q  <= addr2_d;
            data2_q  <= data2_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
            uw_q     <= uw_d;
            rfc_q    <= rfc_d;
            uts_q    <= uts_d;
            busy_q   <= busy_d;
        end
    end

    assign updateWeight     = uw_q;
    assign rfClear          = rfc_q;
    assign clr_ack          = rfc_q;
    assign updateTotalSteps = uts_q;
    assign step_ready       = uts_q;
    assign Addr1            = addr1_q;
    assign Addr2            = addr2_q;
    assign Data1            = data1_q;
    assign Data2            = data2_q;
    assign updatedSteps     = steps_q;
    assign busy             = busy_q;
    assign err_addr         = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_regfile_sequencer;

    localparam int HT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid, wr_ready, wr_last;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr_req, clr_ack;
    logic       step_valid, step_ready;
    logic [7:0] step_count;
    logic       updateWeight, rfClear, updateTotalSteps;
    logic [2:0] Addr1, Addr2;
    logic [7:0] Data1, Data2, updatedSteps;
    logic       busy, err_addr;

    regfile_sequencer #(.HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .clr_req(clr_req), .clr_ack(clr_ack),
        .step_valid(step_valid), .step_count(step_count),
        .step_ready(step_ready),
        .updateWeight(updateWeight), .rfClear(rfClear),
        .updateTotalSteps(updateTotalSteps),
        .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1), .Data2(Data2),
        .updatedSteps(updatedSteps), .busy(busy), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 8'd0;
        clr_req    = 1'b0;
        step_valid = 1'b0;
        step_count = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_uw"}, updateWeight, 0);
        chk({tag, "_rfc"}, rfClear, 0);
        chk({tag, "_uts"}, updateTotalSteps, 0);
        chk({tag, "_ack"}, clr_ack, 0);
        chk({tag, "_srdy"}, step_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_addr, 0);
        chk({tag, "_wrdy"}, wr_ready, 0);
        chk({tag, "_ops"}, {Addr1, Addr2, Data1, Data2}, 0);
        chk({tag, "_steps"}, updatedSteps, 0);
    endtask

    // Count weight strobes over n cycles; used to prove nothing leaks out.
    task automatic count_uw(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (updateWeight === 1'b1) cnt++;
        end
    endtask

    typedef struct {
        string      nm;
        logic [2:0] a0;
        logic [7:0] d0;
        logic       l0;
        bit         two;
        logic [2:0] a1;
        logic [7:0] d1;
        logic       l1;
        int         lat;
        logic [2:0] ea1;
        logic [7:0] ed1;
        logic [2:0] ea2;
        logic [7:0] ed2;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = v.a0;
        wr_data  = v.d0;
        wr_last  = v.l0;
        #1 chk({v.nm, "_rdy0"}, wr_ready, 1);
        @(posedge clk);
        #1;
        if (v.two) begin
            wr_addr = v.a1;
            wr_data = v.d1;
            wr_last = v.l1;
            #1 chk({v.nm, "_rdy1"}, wr_ready, 1);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (updateWeight === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({v.nm, "_lat"}, lat, v.lat);
        chk({v.nm, "_rfc"}, rfClear, 0);
        chk({v.nm, "_a1d1"}, {Addr1, Data1}, {v.ea1, v.ed1});
        chk({v.nm, "_a2d2"}, {Addr2, Data2}, {v.ea2, v.ed2});
        @(negedge clk);
        chk({v.nm, "_uw_off"}, updateWeight, 0);
        chk({v.nm, "_idle"}, busy, 0);
    endtask

    // Reference model state: a held write, how long it has waited,
    // and the single-cycle action the block should be presenting.
    localparam int A_NONE = 0, A_ISSUE = 1, A_CLR = 2, A_STEP = 3;
    int         m_act;
    bit         m_held;
    int         m_wait;
    logic [2:0] m_ha;
    logic [7:0] m_hd;
    logic [2:0] m_o1a, m_o2a;
    logic [7:0] m_o1d, m_o2d;
    logic [7:0] m_steps;
    bit         m_err;

    task automatic model_clear();
        m_act = A_NONE;
        m_held = 0;
        m_wait = 0;
        m_ha = 0;
        m_hd = 0;
        m_o1a = 0;
        m_o2a = 0;
        m_o1d = 0;
        m_o2d = 0;
        m_steps = 0;
        m_err = 0;
    endtask

    function automatic bit model_ready(bit clr, bit stp);
        return (m_act == A_NONE) && !clr && (m_held || !stp);
    endfunction

    task automatic model_issue(input logic [2:0] a1, input logic [7:0] d1,
                               input logic [2:0] a2, input logic [7:0] d2);
        m_act = A_ISSUE;
        m_o1a = a1;
        m_o1d = d1;
        m_o2a = a2;
        m_o2d = d2;
        m_held = 0;
    endtask

    task automatic model_step(input bit clr, input bit stp,
                              input logic [7:0] cnt, input bit acc,
                              input logic [2:0] a, input logic [7:0] d,
                              input bit last);
        bit legal;
        legal = (a <= 3'd5);
        if (acc && !legal) m_err = 1;
        if (m_act != A_NONE) begin
            m_act = A_NONE;
        end else if (!m_held) begin
            if (clr) m_act = A_CLR;
            else if (stp) begin
                m_act = A_STEP;
                m_steps = cnt;
            end else if (acc && legal) begin
                if (last) model_issue(a, d, a, d);
                else begin
                    m_held = 1;
                    m_wait = 0;
                    m_ha = a;
                    m_hd = d;
                end
            end
        end else begin
            if (clr) begin
                m_held = 0;
                m_act = A_CLR;
            end else if (acc && legal) begin
                model_issue(m_ha, m_hd, a, d);
            end else if (!acc) begin
                m_wait++;
                if (m_wait >= HT - 1) model_issue(m_ha, m_hd, m_ha, m_hd);
            end
        end
    endtask

    task automatic model_compare(input int cyc);
        bit e_uw;
        e_uw = (m_act == A_ISSUE) || (m_act == A_CLR);
        chk($sformatf("rnd%0d_uw", cyc), updateWeight, e_uw);
        chk($sformatf("rnd%0d_rfc", cyc), {rfClear, clr_ack},
            {2{m_act == A_CLR}});
        chk($sformatf("rnd%0d_uts", cyc), {updateTotalSteps, step_ready},
            {2{m_act == A_STEP}});
        chk($sformatf("rnd%0d_busy", cyc), busy,
            (m_act != A_NONE) || m_held);
        chk($sformatf("rnd%0d_err", cyc), err_addr, m_err);
        chk($sformatf("rnd%0d_steps", cyc), updatedSteps, m_steps);
        if (m_act == A_ISSUE)
            chk($sformatf("rnd%0d_ops", cyc), {Addr1, Data1, Addr2, Data2},
                {m_o1a, m_o1d, m_o2a, m_o2d});
    endtask

    initial begin
        int cnt;
        int pw;
        bit acc;
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rdy", wr_ready, 1);
        chk("post_reset_busy", busy, 0);

        vecs[0] = '{"pair", 3'd2, 8'h11, 1'b0, 1, 3'd4, 8'h22, 1'b0,
                    1, 3'd2, 8'h11, 3'd4, 8'h22};
        vecs[1] = '{"flush", 3'd1, 8'h55, 1'b1, 0, 3'd0, 8'h00, 1'b0,
                    1, 3'd1, 8'h55, 3'd1, 8'h55};
        vecs[2] = '{"timeout", 3'd3, 8'h07, 1'b0, 0, 3'd0, 8'h00, 1'b0,
                    HT, 3'd3, 8'h07, 3'd3, 8'h07};
        vecs[3] = '{"collide", 3'd5, 8'hAA, 1'b0, 1, 3'd5, 8'hBB, 1'b0,
                    1, 3'd5, 8'hAA, 3'd5, 8'hBB};
        vecs[4] = '{"pairlast", 3'd0, 8'h01, 1'b0, 1, 3'd3, 8'h02, 1'b1,
                    1, 3'd0, 8'h01, 3'd3, 8'h02};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Clear pre-empts a held write, which must never be issued.
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 3'd0;
        wr_data  = 8'h09;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        clr_req  = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        @(negedge clk);
        chk("clr_strobes", {rfClear, updateWeight, clr_ack}, 3'b111);
        count_uw(12, cnt);
        chk("clr_discard", cnt, 0);

        // Persistent clear request restarts after each return to idle.
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        chk("clr_rep0", clr_ack, 1);
        @(negedge clk);
        chk("clr_rep1", clr_ack, 0);
        @(negedge clk);
        chk("clr_rep2", clr_ack, 1);
        clr_req = 1'b0;
        @(negedge clk);

        // Step wins over a simultaneous write, which follows afterwards.
        step_valid = 1'b1;
        step_count = 8'h2A;
        wr_valid   = 1'b1;
        wr_addr    = 3'd1;
        wr_data    = 8'h33;
        wr_last    = 1'b1;
        #1 chk("arb_rdy", wr_ready, 0);
        @(posedge clk);
        #1 step_valid = 1'b0;
        @(negedge clk);
        chk("arb_step", {updateTotalSteps, step_ready, updateWeight}, 3'b110);
        chk("arb_steps", updatedSteps, 8'h2A);
        chk("arb_step_rdy", wr_ready, 0);
        @(negedge clk);
        chk("arb_idle_rdy", wr_ready, 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clk);
        chk("arb_wr", {updateWeight, updateTotalSteps, Addr1, Data1},
            {2'b10, 3'd1, 8'h33});

        // Illegal address: sticky error, write dropped.
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 3'd7;
        wr_data  = 8'hFF;
        wr_last  = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clk);
        chk("err_set", {err_addr, updateWeight, busy}, 3'b100);
        count_uw(4, cnt);
        chk("err_nouw", cnt, 0);
        chk("err_sticky", err_addr, 1);

        // Asynchronous reset in the middle of a hold.
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 8'h44;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        chk("hold_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        count_uw(12, cnt);
        chk("rst_nouw", cnt, 0);
        chk("rst_busy", busy, 0);

        // Randomized traffic against the reference model.
        idle_in();
        do_reset();
        model_clear();
        pw = 50;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            model_compare(c);
            if (c % 200 == 0) pw = $urandom_range(15, 85);
            clr_req    = ($urandom_range(0, 99) < 5);
            step_valid = ($urandom_range(0, 99) < 8);
            step_count = 8'($urandom);
            wr_valid   = ($urandom_range(0, 99) < pw);
            wr_addr    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                     : 3'($urandom_range(0, 5));
            wr_data    = 8'($urandom);
            wr_last    = ($urandom_range(0, 99) < 20);
            #1;
            acc = wr_valid && model_ready(clr_req, step_valid);
            chk($sformatf("rnd%0d_rdy", c), wr_ready,
                model_ready(clr_req, step_valid));
            @(posedge clk);
            model_step(clr_req, step_valid, step_count, acc,
                       wr_addr, wr_data, wr_last);
        end
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
